// File: rtl/ctrl_pipeline_pkg.sv
// Shared types and encodings for the control pipeline: per-stage packed bundles,
// writeback-source encodings and the saturating event-counter helper.
package ctrl_pipeline_pkg;

   localparam logic [1:0] REGSEL_ALU   = 2'b00;
   localparam logic [1:0] REGSEL_PC4   = 2'b01;
   localparam logic [1:0] REGSEL_LUI   = 2'b10;
   localparam logic [1:0] REGSEL_AUIPC = 2'b11;

   typedef struct packed {
      logic       branch;
      logic       memread;
      logic       memtoreg;
      logic       memwrite;
      logic       alusrc;
      logic       regwrite;
      logic       jalr_jump;
      logic       jal_jump;
      logic [1:0] regwrite_sel;
      logic [2:0] aluop;
      logic [4:0] rd;
      logic       valid;
   } idex_t;

   typedef struct packed {
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       regwrite;
      logic [1:0] regwrite_sel;
      logic [4:0] rd;
      logic       valid;
   } exmem_t;

   typedef struct packed {
      logic       memtoreg;
      logic       regwrite;
      logic [1:0] regwrite_sel;
      logic [4:0] rd;
      logic       valid;
   } memwb_t;

   localparam int BUBBLE_W = $bits(idex_t);

   function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
      return (en && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
   endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline control register: 1-cycle latency, loads all-zero on bubble.
// hold freezes contents; rst (sync, active-high) clears to bubble and beats hold.
module ctrl_stage_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         hold,
   input  logic         bubble,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst)
         q <= '0;
      else if (!hold)
         q <= bubble ? '0 : d;
   end

endmodule

// File: rtl/ctrl_pipeline.sv
// Decoder control bundle through ID/EX, EX/MEM, MEM/WB (1/2/3 cycles, +hold cycles).
// Load-use stall and redirect flush are combinational; hold freezes every stage.
module ctrl_pipeline
   import ctrl_pipeline_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic        id_branch,
   input  logic        id_memread,
   input  logic        id_memtoreg,
   input  logic        id_memwrite,
   input  logic        id_alusrc,
   input  logic        id_regwrite,
   input  logic        id_jalr_jump,
   input  logic        id_jal_jump,
   input  logic [1:0]  id_regwrite_sel,
   input  logic [2:0]  id_aluop,
   input  logic [4:0]  id_rd,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        ex_redirect,
   output logic        stall,
   output logic        flush_ifid,
   output logic        ex_branch,
   output logic        ex_memread,
   output logic        ex_memtoreg,
   output logic        ex_memwrite,
   output logic        ex_alusrc,
   output logic        ex_regwrite,
   output logic        ex_jalr_jump,
   output logic        ex_jal_jump,
   output logic [1:0]  ex_regwrite_sel,
   output logic [2:0]  ex_aluop,
   output logic [4:0]  ex_rd,
   output logic        ex_valid,
   output logic        mem_memread,
   output logic        mem_memwrite,
   output logic        mem_memtoreg,
   output logic        mem_regwrite,
   output logic [1:0]  mem_regwrite_sel,
   output logic [4:0]  mem_rd,
   output logic        mem_valid,
   output logic        wb_memtoreg,
   output logic        wb_regwrite,
   output logic [1:0]  wb_regwrite_sel,
   output logic [4:0]  wb_rd,
   output logic        wb_valid,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count
);

   idex_t  id_bundle, idex_q;
   exmem_t exmem_d, exmem_q;
   memwb_t memwb_d, memwb_q;

   logic id_active, uses_rs1, uses_rs2, load_use, idex_bubble;

   // Hazard detection looks only at the instruction sitting in ID/EX.
   assign id_active = id_regwrite | id_memwrite | id_branch;
   assign uses_rs1  = id_active & ~id_jal_jump & ~id_regwrite_sel[1];
   assign uses_rs2  = id_memwrite |
                      (id_active & ~id_alusrc & ~id_jal_jump & ~id_jalr_jump &
                       (id_regwrite_sel == REGSEL_ALU));
   assign load_use  = idex_q.memread & (idex_q.rd != 5'd0) &
                      ((uses_rs1 & (idex_q.rd == id_rs1)) |
                       (uses_rs2 & (idex_q.rd == id_rs2)));

   assign stall       = load_use & ~ex_redirect & ~hold;
   assign flush_ifid  = ex_redirect & ~hold;
   assign idex_bubble = ex_redirect | load_use;

   always_comb begin
      id_bundle              = '0;
      id_bundle.branch       = id_branch;
      id_bundle.memread      = id_memread;
      id_bundle.memtoreg     = id_memtoreg;
      id_bundle.memwrite     = id_memwrite;
      id_bundle.alusrc       = id_alusrc;
      id_bundle.regwrite     = id_regwrite;
      id_bundle.jalr_jump    = id_jalr_jump;
      id_bundle.jal_jump     = id_jal_jump;
      id_bundle.regwrite_sel = id_regwrite_sel;
      id_bundle.aluop        = id_aluop;
      id_bundle.rd           = id_regwrite ? id_rd : 5'd0;
      id_bundle.valid        = id_active | id_jal_jump | id_jalr_jump;
   end

   // A write to x0 is dropped from MEM onward so forwarding never sees it.
   always_comb begin
      exmem_d              = '0;
      exmem_d.memread      = idex_q.memread;
      exmem_d.memwrite     = idex_q.memwrite;
      exmem_d.memtoreg     = idex_q.memtoreg;
      exmem_d.regwrite     = idex_q.regwrite & (idex_q.rd != 5'd0);
      exmem_d.regwrite_sel = idex_q.regwrite_sel;
      exmem_d.rd           = exmem_d.regwrite ? idex_q.rd : 5'd0;
      exmem_d.valid        = idex_q.valid;
   end

   always_comb begin
      memwb_d              = '0;
      memwb_d.memtoreg     = exmem_q.memtoreg;
      memwb_d.regwrite     = exmem_q.regwrite & (exmem_q.rd != 5'd0);
      memwb_d.regwrite_sel = exmem_q.regwrite_sel;
      memwb_d.rd           = memwb_d.regwrite ? exmem_q.rd : 5'd0;
      memwb_d.valid        = exmem_q.valid;
   end

   ctrl_stage_reg #(.W(BUBBLE_W)) u_idex (
      .clk    (clk),
      .rst    (rst),
      .hold   (hold),
      .bubble (idex_bubble),
      .d      (id_bundle),
      .q      (idex_q)
   );

   ctrl_stage_reg #(.W($bits(exmem_t))) u_exmem (
      .clk    (clk),
      .rst    (rst),
      .hold   (hold),
      .bubble (1'b0),
      .d      (exmem_d),
      .q      (exmem_q)
   );

   ctrl_stage_reg #(.W($bits(memwb_t))) u_memwb (
      .clk    (clk),
      .rst    (rst),
      .hold   (hold),
      .bubble (1'b0),
      .d      (memwb_d),
      .q      (memwb_q)
   );

   // stall and flush_ifid are already masked by hold, so counters freeze with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= 16'd0;
         flush_count <= 16'd0;
      end else begin
         stall_count <= sat_inc(stall_count, stall);
         flush_count <= sat_inc(flush_count, flush_ifid);
      end
   end

   assign ex_branch       = idex_q.branch;
   assign ex_memread      = idex_q.memread;
   assign ex_memtoreg     = idex_q.memtoreg;
   assign ex_memwrite     = idex_q.memwrite;
   assign ex_alusrc       = idex_q.alusrc;
   assign ex_regwrite     = idex_q.regwrite;
   assign ex_jalr_jump    = idex_q.jalr_jump;
   assign ex_jal_jump     = idex_q.jal_jump;
   assign ex_regwrite_sel = idex_q.regwrite_sel;
   assign ex_aluop        = idex_q.aluop;
   assign ex_rd           = idex_q.rd;
   assign ex_valid        = idex_q.valid;

   assign mem_memread      = exmem_q.memread;
   assign mem_memwrite     = exmem_q.memwrite;
   assign mem_memtoreg     = exmem_q.memtoreg;
   assign mem_regwrite     = exmem_q.regwrite;
   assign mem_regwrite_sel = exmem_q.regwrite_sel;
   assign mem_rd           = exmem_q.rd;
   assign mem_valid        = exmem_q.valid;

   assign wb_memtoreg     = memwb_q.memtoreg;
   assign wb_regwrite     = memwb_q.regwrite;
   assign wb_regwrite_sel = memwb_q.regwrite_sel;
   assign wb_rd           = memwb_q.rd;
   assign wb_valid        = memwb_q.valid;

endmodule

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

Carries the per-instruction control bundle produced by the ID-stage decoder down the pipeline through the ID/EX, EX/MEM and MEM/WB control registers. It detects load-use hazards and emits the stall, and squashes wrong-path instructions on a taken branch or jump. It sits between the instruction decoder and the EX/MEM/WB datapath, and is the only consumer of the decoder's control outputs.

## Interface
Parameters:
- none. Encodings of aluop and regwrite_sel come from `include/defines.v`.

Ports:
- clk  in  1  system clock. One clock domain; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  global freeze (memory busy). All stage registers keep their values.
- id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite, id_jalr_jump, id_jal_jump  in  1 each  decoder outputs for the instruction in ID.
- id_regwrite_sel  in  2  writeback source select: 00 ALU/mem, 01 PC+4, 10 LUI imm, 11 AUIPC.
- id_aluop  in  3  ALU op class.
- id_rd, id_rs1, id_rs2  in  5 each  register fields of the ID instruction.
- ex_redirect  in  1  taken branch, JAL or JALR resolved in EX this cycle.
- stall  out  1  hold PC and IF/ID; combinational.
- flush_ifid  out  1  invalidate IF/ID; combinational, equals ex_redirect & !hold.
- ex_* (all ten bundle fields plus ex_rd, ex_valid)  out  registered ID/EX contents.
- mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, mem_regwrite_sel[1:0], mem_rd[4:0], mem_valid  out  registered EX/MEM contents.
- wb_memtoreg, wb_regwrite, wb_regwrite_sel[1:0], wb_rd[4:0], wb_valid  out  registered MEM/WB contents.
- stall_count, flush_count  out  16 each  saturating event counters.

## Operation
- Bubble: every field is 0 and valid is 0. The default/no-op decode also produces all-zero fields.
- id_active = id_regwrite | id_memwrite | id_branch.
- uses_rs1 = id_active & !id_jal_jump & (id_regwrite_sel[1] == 0).
- uses_rs2 = id_memwrite | (id_active & !id_alusrc & !id_jal_jump & !id_jalr_jump & id_regwrite_sel == 00).
- load_use = ex_memread & ex_rd != 0 & ((uses_rs1 & ex_rd == id_rs1) | (uses_rs2 & ex_rd == id_rs2)).
- stall = load_use & !ex_redirect & !hold.
- Priority per edge, highest first:
  1. rst: all registers cleared to bubble, counters cleared.
  2. hold: no register changes, counters unchanged.
  3. ex_redirect: ID/EX loads a bubble (ID is wrong-path) and flush_ifid is asserted. EX/MEM and MEM/WB advance normally; the redirecting instruction itself completes.
  4. load_use: ID/EX loads a bubble, EX/MEM and MEM/WB advance, stall=1.
  5. Otherwise ID/EX loads the ID bundle with valid=1 when id_active or jump, else 0.
- EX/MEM takes its fields from ID/EX; MEM/WB takes its fields from EX/MEM. Both update every non-hold cycle.
- rd is forced to 0 in any stage whose regwrite is 0. mem_regwrite and wb_regwrite are forced to 0 when rd == 0.
- stall_count increments on each cycle with stall=1. flush_count increments on each cycle with flush_ifid=1. Both saturate at 0xFFFF.

## Timing
- Reset values: every registered output is 0; stall=0, flush_ifid=0 when ex_redirect=0; counters are 0.
- Latency: ID bundle appears on ex_* 1 cycle later, mem_* 2 cycles later and wb_* 3 cycles later, each extended by hold cycles.
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in MEM, so load_use is false.
- When redirect and load_use occur together, only the redirect is acted on: stall=0.
- hold asserted in the same cycle as a redirect suppresses the flush. The redirect must be re-presented by EX, which is held, on the next cycle.
- rst asserted mid-stall or mid-flush clears everything on that edge. The first cycle after reset has no stall.

## Structure
- Add to `include/defines.v`: REGSEL_* encodings (00/01/10/11) and a bubble-width constant.
- One sub-module, `ctrl_stage_reg`: a parameterised-width register with synchronous rst, hold and bubble inputs. Instantiate it three times.
- Hazard and redirect logic stays combinational in the top level.

## Test plan
- Reset: hold rst for 2 cycles with random inputs, then release → all outputs 0, counters 0.
- Load-use: lw x5 in ID, next add x6,x5,x1 → stall=1 for one cycle, bubble on ex_* (ex_valid=0), add reaches EX one cycle late, stall_count=1.
- Load with rd=x0 followed by a reader of x0 → no stall.
- Redirect: beq in EX with ex_redirect=1 and add in ID → flush_ifid=1, ex_* bubble next cycle, beq's fields reach mem_*, flush_count=1.
- Redirect and load_use in the same cycle → stall=0, flush_ifid=1, counters +0 stall / +1 flush.
- hold for 3 cycles in the middle of a 3-instruction stream → all stage outputs frozen; the stream resumes with no instruction lost or duplicated. 70000 forced stalls → stall_count=0xFFFF.
